// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator side of the data-memory port.
//   Takes one load/store request at a time (valid/ready), runs a single RAM
//   access cycle, aligns and extends load data, and returns the result with
//   its destination register over a valid/ready response handshake.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   req_*           request channel (op, byte address, store data, dest reg)
//   resp_*          response channel (extended data, dest reg, wreg, excp)
//   stall_req       request waiting while the controller is busy
//   mem_*           RAM chip-enable, write-enable, address, byte lanes, data
//
// Build option:
//   MEM_ALIGN_CHECK_EN  misaligned halfword/word requests skip the RAM access
//                       and return resp_excp=1; when undefined resp_excp is 0
//                       and low address bits are ignored for alignment.

module mem_access_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [REG_ADDR_W-1:0] req_wd,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic [REG_ADDR_W-1:0] resp_wd,
    output logic                  resp_wreg,
    output logic                  resp_excp,
    output logic                  stall_req,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [3:0]            mem_sel,
    output logic [31:0]           mem_data_o,
    input  logic [31:0]           mem_data_i
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_LB  = OP_W'(4'h0);
    localparam logic [OP_W-1:0] OP_LBU = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OP_LH  = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OP_LHU = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OP_LW  = OP_W'(4'h4);
    localparam logic [OP_W-1:0] OP_SB  = OP_W'(4'h8);
    localparam logic [OP_W-1:0] OP_SH  = OP_W'(4'h9);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(4'hA);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } size_e;

    // Access size of an opcode; anything outside the decoded set is a NOP.
    function automatic size_e op_size(input logic [OP_W-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            OP_LW, OP_SW:         return SZ_WORD;
            default:              return SZ_NONE;
        endcase
    endfunction

    // Big-endian byte lanes: address offset 0 lives in data[31:24].
    function automatic logic [SEL_W-1:0] lane_sel(input size_e sz, input logic [1:0] a);
        logic [SEL_W-1:0] sel;
        sel = '0;
        case (sz)
            SZ_BYTE: begin
                case (a)
                    2'b00:   sel = 4'b1000;
                    2'b01:   sel = 4'b0100;
                    2'b10:   sel = 4'b0010;
                    default: sel = 4'b0001;
                endcase
            end
            SZ_HALF: sel = a[1] ? 4'b0011 : 4'b1100;
            SZ_WORD: sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // Replicate store data across all lanes so any selected lane carries it.
    function automatic logic [DATA_W-1:0] store_data(input size_e sz, input logic [DATA_W-1:0] w);
        case (sz)
            SZ_BYTE: return {4{w[7:0]}};
            SZ_HALF: return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    // Move the addressed lane down to bit 0 and extend per the load opcode.
    function automatic logic [DATA_W-1:0] load_extract(input logic [OP_W-1:0] op,
                                                      input logic [1:0] a,
                                                      input logic [DATA_W-1:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'b00:   b = d[31:24];
            2'b01:   b = d[23:16];
            2'b10:   b = d[15:8];
            default: b = d[7:0];
        endcase
        h = a[1] ? d[15:0] : d[31:16];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0, h};
            default: return d;
        endcase
    endfunction

    state_e                state_q,      state_d;
    logic [OP_W-1:0]       op_q,         op_d;
    logic                  idle_q,       idle_d;
    logic                  mem_ce_q,     mem_ce_d;
    logic                  mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q,   mem_addr_d;
    logic [SEL_W-1:0]      mem_sel_q,    mem_sel_d;
    logic [DATA_W-1:0]     mem_data_o_q, mem_data_o_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
    logic [REG_ADDR_W-1:0] resp_wd_q,    resp_wd_d;
    logic                  resp_wreg_q,  resp_wreg_d;
    logic                  resp_excp_q,  resp_excp_d;

    size_e req_size_c;
    logic  req_is_store_c;
    logic  req_is_mem_c;
    logic  req_misaligned_c;

    // Request decode (only meaningful in IDLE).
    assign req_size_c     = op_size(req_op);
    assign req_is_store_c = (req_op == OP_SB) || (req_op == OP_SH) || (req_op == OP_SW);
    assign req_is_mem_c   = (req_size_c != SZ_NONE);

`ifdef MEM_ALIGN_CHECK_EN
    assign req_misaligned_c = ((req_size_c == SZ_HALF) && req_addr[0]) ||
                              ((req_size_c == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign req_misaligned_c = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        mem_ce_d     = mem_ce_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_sel_d    = mem_sel_q;
        mem_data_o_d = mem_data_o_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_wd_d    = resp_wd_q;
        resp_wreg_d  = resp_wreg_q;
        resp_excp_d  = resp_excp_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d      = req_op;
                    resp_wd_d = req_wd;
                    if (req_is_mem_c && !req_misaligned_c) begin
                        state_d      = ST_ACCESS;
                        mem_ce_d     = 1'b1;
                        mem_we_d     = req_is_store_c;
                        mem_addr_d   = req_addr;
                        mem_sel_d    = lane_sel(req_size_c, req_addr[1:0]);
                        mem_data_o_d = req_is_store_c ? store_data(req_size_c, req_wdata)
                                                      : '0;
                    end else begin
                        // NOPs and rejected misaligned accesses never touch the RAM.
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_wreg_d  = 1'b0;
                        resp_excp_d  = req_misaligned_c;
                    end
                end
            end
            ST_ACCESS: begin
                // RAM write / read completes on the edge leaving this state.
                state_d      = ST_RESP;
                mem_ce_d     = 1'b0;
                mem_we_d     = 1'b0;
                resp_valid_d = 1'b1;
                resp_wreg_d  = !op_q[3];
                resp_excp_d  = 1'b0;
                resp_rdata_d = op_q[3] ? '0 : load_extract(op_q, mem_addr_q[1:0], mem_data_i);
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                mem_ce_d     = 1'b0;
                mem_we_d     = 1'b0;
                resp_valid_d = 1'b0;
            end
        endcase

        idle_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            idle_q       <= 1'b1;
            mem_ce_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_sel_q    <= '0;
            mem_data_o_q <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_wd_q    <= '0;
            resp_wreg_q  <= 1'b0;
            resp_excp_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            idle_q       <= idle_d;
            mem_ce_q     <= mem_ce_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_sel_q    <= mem_sel_d;
            mem_data_o_q <= mem_data_o_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_wd_q    <= resp_wd_d;
            resp_wreg_q  <= resp_wreg_d;
            resp_excp_q  <= resp_excp_d;
        end
    end

    assign req_ready  = idle_q;
    assign stall_req  = req_valid && !idle_q;
    assign mem_ce     = mem_ce_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_sel    = mem_sel_q;
    assign mem_data_o = mem_data_o_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_wd    = resp_wd_q;
    assign resp_wreg  = resp_wreg_q;
    assign resp_excp  = resp_excp_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the data-memory port. Sits between the MEM pipeline stage and the data RAM.
- Accepts one load/store request at a time over a valid/ready handshake and drives the RAM chip-enable, write-enable, address, byte-select and write-data lines.
- Aligns and sign-/zero-extends read data for loads, then returns the result with its destination register over a valid/ready response handshake.

Parameters:
ADDR_W, 32, byte address width on request and RAM sides
REG_ADDR_W, 5, destination register index width

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset; one clock, asynchronous and active-low
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  4  0=LB 1=LBU 2=LH 3=LHU 4=LW 8=SB 9=SH A=SW; all other codes are NOP
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
req_wd  in  REG_ADDR_W  load destination register
resp_valid  out  1  response present
resp_ready  in  1  consumer takes the response
resp_rdata  out  32  extended load data; 0 for stores and NOPs
resp_wd  out  REG_ADDR_W  destination register, echoed from the request
resp_wreg  out  1  1 only for a completed load
resp_excp  out  1  misaligned access (see Optional Feature)
stall_req  out  1  req_valid && !req_ready
mem_ce  out  1  RAM chip enable (1 = enabled)
mem_we  out  1  RAM write enable (1 = write)
mem_addr  out  ADDR_W  RAM byte address
mem_sel  out  4  byte lanes; sel[3] selects data[31:24]
mem_data_o  out  32  RAM write data
mem_data_i  in  32  RAM read data; combinational, valid in the same cycle

Behaviour:
- Reset:
  - state=IDLE.
  - All registered outputs are 0: resp_*, mem_ce, mem_we, mem_addr, mem_sel, mem_data_o.
  - req_ready=1 once reset is released.
  - Reset asserted mid-access deasserts mem_ce/mem_we asynchronously, and no write may occur. Any held response is discarded.
- FSM states: IDLE, ACCESS, RESP.
  - req_ready = (state==IDLE).
- IDLE:
  - On req_valid at a rising edge, register the request.
  - Loads/stores go to ACCESS.
  - NOPs go straight to RESP with resp_wreg=0 and resp_rdata=0.
- ACCESS (exactly one cycle):
  - mem_ce=1.
  - mem_we=1 for stores, 0 for loads.
  - mem_addr = request address.
  - mem_sel and mem_data_o are registered on entry to ACCESS.
  - The RAM writes at the edge that ends ACCESS.
  - For loads, mem_data_i is aligned, extended and captured into resp_rdata at that same edge.
  - Then go to RESP. mem_ce and mem_we return to 0 in RESP.
- Byte lanes (big-endian), keyed on addr[1:0]:
  - Byte access: 00→1000, 01→0100, 10→0010, 11→0001.
  - Halfword access: addr[1]=0→1100, addr[1]=1→0011.
  - Word access: 1111.
- Store data replication:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extraction:
  - The selected lane is moved to bits [7:0] or [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- RESP:
  - resp_valid=1; all resp_* outputs are held stable until resp_valid && resp_ready.
  - On handshake, go to IDLE; req_ready rises the following cycle.
- Best-case latency: accept at edge E0, RAM access in cycle E0–E1, resp_valid from E1, handshake at E2. Issue interval is 3 cycles.
- A request presented while not in IDLE is not accepted; stall_req=1 while it waits.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A halfword request with addr[0]=1, or a word request with addr[1:0]≠00, skips ACCESS: no mem_ce, no write.
  - It goes IDLE→RESP with resp_excp=1, resp_wreg=0, resp_rdata=0.
- Undefined:
  - resp_excp is tied to 0.
  - Low address bits are ignored for alignment: halfword uses addr[1] only, word uses lanes 1111.
  - mem_addr carries the address unmodified.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 → ACCESS cycle shows mem_sel=1111 and mem_we=1; LW response resp_rdata=0xDEADBEEF, resp_wreg=1, resp_valid at E1.
- SB addr=0x21 wdata=0x000000A5 → mem_sel=0100, mem_data_o=0xA5A5A5A5. A following LB addr=0x21 returns 0xFFFFFFA5; LBU addr=0x21 returns 0x000000A5.
- SH addr=0x32 wdata=0x8001 → mem_sel=0011. LH returns 0xFFFF8001; LHU returns 0x00008001.
- Hold resp_ready=0 for 5 cycles with a second request pending → resp_* stable, req_ready=0 and stall_req=1 throughout. The second request is accepted only in the cycle after the handshake.
- Assert rst low during ACCESS of SW addr=0x40 → mem_ce and mem_we drop immediately; a subsequent LW addr=0x40 returns the pre-store value.
- With MEM_ALIGN_CHECK_EN, LW addr=0x42 → mem_ce never asserts; resp_excp=1, resp_wreg=0. Without the macro, the same request returns the word at 0x40.
